// File: rtl/fm_backward_step_if.sv
// Bundled command / C-table / Occ / result ports of the FM backward-extension engine.
// Every valid/ready pair transfers exactly on a cycle where both are high; the payload is held stable while valid && !ready.
interface fm_backward_step_if #(
  parameter int IDX_W   = 8,
  parameter int ALPHA_W = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [IDX_W-1:0]   cmd_k;
  logic [IDX_W-1:0]   cmd_l;
  logic [ALPHA_W-1:0] cmd_sym;
  logic               cmd_all;

  logic               c_ce;
  logic [ALPHA_W-1:0] c_addr;
  logic [IDX_W-1:0]   c_data;

  logic               occ_req_valid;
  logic               occ_req_ready;
  logic [ALPHA_W-1:0] occ_sym;
  logic [IDX_W-1:0]   occ_pos;
  logic               occ_rsp_valid;
  logic [IDX_W-1:0]   occ_rsp_data;

  logic               res_valid;
  logic               res_ready;
  logic [ALPHA_W-1:0] res_sym;
  logic [IDX_W-1:0]   res_k;
  logic [IDX_W-1:0]   res_l;
  logic               res_empty;
  logic               res_last;

  modport master (
    input  cmd_valid, cmd_k, cmd_l, cmd_sym, cmd_all,
    output cmd_ready,
    output c_ce, c_addr,
    input  c_data,
    output occ_req_valid, occ_sym, occ_pos,
    input  occ_req_ready, occ_rsp_valid, occ_rsp_data,
    output res_valid, res_sym, res_k, res_l, res_empty, res_last,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_k, cmd_l, cmd_sym, cmd_all,
    input  cmd_ready,
    input  c_ce, c_addr,
    output c_data,
    input  occ_req_valid, occ_sym, occ_pos,
    output occ_req_ready, occ_rsp_valid, occ_rsp_data,
    input  res_valid, res_sym, res_k, res_l, res_empty, res_last,
    output res_ready
  );
endinterface

// File: rtl/fm_backward_step.sv
// FM-index backward extension: k' = C(a)+Occ(a,k-1)+1, l' = C(a)+Occ(a,l) for one symbol or all symbols.
// C and Occ are fetched over handshaked ports; results leave on a valid/ready stream.
module fm_backward_step #(
  parameter int IDX_W   = 8,
  parameter int ALPHA_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  fm_backward_step_if.master  bus,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_C  = 3'd1;
  localparam logic [2:0] S_RD_OK = 3'd2;
  localparam logic [2:0] S_WT_OK = 3'd3;
  localparam logic [2:0] S_RD_OL = 3'd4;
  localparam logic [2:0] S_WT_OL = 3'd5;
  localparam logic [2:0] S_EMIT  = 3'd6;

  localparam logic [IDX_W-1:0]   IDX_ONE = 1;
  localparam logic [ALPHA_W-1:0] SYM_ONE = 1;
  localparam logic [ALPHA_W-1:0] SYM_MAX = '1;

  logic [2:0]         state_q;
  logic [IDX_W-1:0]   k_q, l_q, c_q, occk_q, occl_q;
  logic [ALPHA_W-1:0] sym_q;
  logic               all_q, inv_q, c_ce_q;

  logic [IDX_W-1:0]   sum_k, sum_l;
  logic               last, emit, rd_c, req_k, req_l;

  // Sums wrap modulo 2**IDX_W; emptiness is judged on the wrapped values.
  assign sum_k = c_q + occk_q + IDX_ONE;
  assign sum_l = c_q + occl_q;
  assign last  = !all_q || (sym_q == SYM_MAX);

  assign emit  = (state_q == S_EMIT);
  assign rd_c  = (state_q == S_RD_C);
  assign req_k = (state_q == S_RD_OK);
  assign req_l = (state_q == S_RD_OL);

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.c_ce          = rd_c;
  assign bus.c_addr        = rd_c ? sym_q : '0;
  assign bus.occ_req_valid = req_k || req_l;
  assign bus.occ_sym       = (req_k || req_l) ? sym_q : '0;
  assign bus.occ_pos       = req_k ? (k_q - IDX_ONE) : (req_l ? l_q : '0);

  // An inverted input interval (k>l) reports an empty result with zeroed bounds.
  assign bus.res_valid = emit;
  assign bus.res_sym   = emit ? sym_q : '0;
  assign bus.res_k     = (emit && !inv_q) ? sum_k : '0;
  assign bus.res_l     = (emit && !inv_q) ? sum_l : '0;
  assign bus.res_empty = emit && (inv_q || (sum_k > sum_l));
  assign bus.res_last  = emit && last;

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      l_q     <= '0;
      c_q     <= '0;
      occk_q  <= '0;
      occl_q  <= '0;
      sym_q   <= '0;
      all_q   <= 1'b0;
      inv_q   <= 1'b0;
      c_ce_q  <= 1'b0;
    end else begin
      // C table has a fixed one-cycle read latency, independent of FSM state.
      c_ce_q <= rd_c;
      if (c_ce_q) c_q <= bus.c_data;

      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            k_q     <= bus.cmd_k;
            l_q     <= bus.cmd_l;
            all_q   <= bus.cmd_all;
            sym_q   <= bus.cmd_all ? '0 : bus.cmd_sym;
            inv_q   <= (bus.cmd_k > bus.cmd_l);
            state_q <= (bus.cmd_k > bus.cmd_l) ? S_EMIT : S_RD_C;
          end
        end
        S_RD_C: begin
          if (k_q == '0) begin
            occk_q  <= '0;
            state_q <= S_RD_OL;
          end else begin
            state_q <= S_RD_OK;
          end
        end
        S_RD_OK: if (bus.occ_req_ready) state_q <= S_WT_OK;
        S_WT_OK: begin
          if (bus.occ_rsp_valid) begin
            occk_q  <= bus.occ_rsp_data;
            state_q <= S_RD_OL;
          end
        end
        S_RD_OL: if (bus.occ_req_ready) state_q <= S_WT_OL;
        S_WT_OL: begin
          if (bus.occ_rsp_valid) begin
            occl_q  <= bus.occ_rsp_data;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.res_ready) begin
            if (last) begin
              state_q <= S_IDLE;
            end else begin
              sym_q   <= sym_q + SYM_ONE;
              state_q <= inv_q ? S_EMIT : S_RD_C;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_backward_step.sv
// Directed bench for fm_backward_step with C-table and Occ memory models.
module tb_fm_backward_step;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  fm_backward_step_if #(.IDX_W(8), .ALPHA_W(2)) bus ();

  fm_backward_step #(.IDX_W(8), .ALPHA_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] c_mem   [0:3];
  logic [7:0] occ_mem [0:3][0:255];
  logic [7:0] pos_hist[0:255];
  int         c_ce_cnt  = 0;
  int         req_cnt   = 0;
  logic       rsp_en    = 1'b1;
  logic       stale_inj = 1'b0;
  logic       rsp_pend  = 1'b0;
  logic [7:0] rsp_data  = 8'd0;

  // C table: data returned the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.c_ce) begin
      bus.c_data <= c_mem[bus.c_addr];
      c_ce_cnt   <= c_ce_cnt + 1;
    end
  end

  // Occ memory: one response, one cycle after each accepted request.
  always @(posedge clk) begin
    rsp_pend <= 1'b0;
    if (bus.occ_req_valid && bus.occ_req_ready) begin
      pos_hist[req_cnt[7:0]] <= bus.occ_pos;
      req_cnt <= req_cnt + 1;
      if (rsp_en) begin
        rsp_pend <= 1'b1;
        rsp_data <= occ_mem[bus.occ_sym][bus.occ_pos];
      end
    end
  end

  assign bus.occ_rsp_valid = rsp_pend | stale_inj;
  assign bus.occ_rsp_data  = stale_inj ? 8'hAA : rsp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] k, input logic [7:0] l, input logic [1:0] sym, input logic all);
    check("cmd_ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_k     = k;
    bus.cmd_l     = l;
    bus.cmd_sym   = sym;
    bus.cmd_all   = all;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // lat = 1 on the first sample after the accepting edge (cycle T+1).
  task automatic wait_res(output int lat);
    lat = 1;
    while (!bus.res_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("res_valid_within_budget", {31'd0, bus.res_valid}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [1:0] sym, input logic [7:0] k,
                           input logic [7:0] l, input logic empty, input logic last);
    check({tag, "_sym"},   {30'd0, bus.res_sym},   {30'd0, sym});
    check({tag, "_k"},     {24'd0, bus.res_k},     {24'd0, k});
    check({tag, "_l"},     {24'd0, bus.res_l},     {24'd0, l});
    check({tag, "_empty"}, {31'd0, bus.res_empty}, {31'd0, empty});
    check({tag, "_last"},  {31'd0, bus.res_last},  {31'd0, last});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base_c;
    int base_r;
    logic [7:0] e3_k [4] = '{8'd2, 8'd6, 8'd10, 8'd13};
    logic [7:0] e3_l [4] = '{8'd1, 8'd5, 8'd9,  8'd13};
    logic       e3_e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    for (int s = 0; s < 4; s++) begin
      c_mem[s] = 8'd0;
      for (int p = 0; p < 256; p++) occ_mem[s][p] = 8'd0;
    end
    bus.cmd_valid     = 1'b0;
    bus.cmd_k         = 8'd0;
    bus.cmd_l         = 8'd0;
    bus.cmd_sym       = 2'd0;
    bus.cmd_all       = 1'b0;
    bus.occ_req_ready = 1'b1;
    bus.res_ready     = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready},     32'd1);
    check("rst_busy",      {31'd0, busy},              32'd0);
    check("rst_state",     {29'd0, dbg_state},         32'd0);
    check("rst_c_ce",      {31'd0, bus.c_ce},          32'd0);
    check("rst_occ_req",   {31'd0, bus.occ_req_valid}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid},     32'd0);
    check("rst_res_k",     {24'd0, bus.res_k},         32'd0);
    check("rst_res_l",     {24'd0, bus.res_l},         32'd0);

    // 1: single symbol, k=3 l=9 a=2
    c_mem[2] = 8'd10;
    occ_mem[2][2] = 8'd1;
    occ_mem[2][9] = 8'd4;
    base_c = c_ce_cnt;
    base_r = req_cnt;
    send_cmd(8'd3, 8'd9, 2'd2, 1'b0);
    check("t1_c_ce_at_t1",   {31'd0, bus.c_ce},   32'd1);
    check("t1_c_addr",       {30'd0, bus.c_addr}, 32'd2);
    check("t1_cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    wait_res(lat);
    check("t1_latency", lat, 32'd6);
    check_res("t1", 2'd2, 8'd12, 8'd14, 1'b0, 1'b1);
    tick();
    check("t1_idle_after", {31'd0, busy}, 32'd0);
    check("t1_c_ce_count", c_ce_cnt - base_c, 32'd1);
    check("t1_req_count",  req_cnt - base_r,  32'd2);
    check("t1_pos0", {24'd0, pos_hist[base_r]},     32'd2);
    check("t1_pos1", {24'd0, pos_hist[base_r + 1]}, 32'd9);

    // 2: k=0 skips the Occ(a,k-1) request
    c_mem[1] = 8'd4;
    occ_mem[1][5] = 8'd2;
    base_r = req_cnt;
    send_cmd(8'd0, 8'd5, 2'd1, 1'b0);
    wait_res(lat);
    check("t2_latency", lat, 32'd4);
    check_res("t2", 2'd1, 8'd5, 8'd6, 1'b0, 1'b1);
    tick();
    check("t2_req_count", req_cnt - base_r, 32'd1);
    check("t2_pos0", {24'd0, pos_hist[base_r]}, 32'd5);

    // 3: ALL mode, k=l=1; BWT[0]=0, BWT[1]=3
    c_mem[0] = 8'd0;
    c_mem[1] = 8'd5;
    c_mem[2] = 8'd9;
    c_mem[3] = 8'd12;
    occ_mem[0][0] = 8'd1;
    occ_mem[0][1] = 8'd1;
    occ_mem[3][1] = 8'd1;
    base_r = req_cnt;
    send_cmd(8'd1, 8'd1, 2'd2, 1'b1);
    for (int s = 0; s < 4; s++) begin
      wait_res(lat);
      check_res($sformatf("t3_s%0d", s), s[1:0], e3_k[s], e3_l[s], e3_e[s], (s == 3));
      tick();
    end
    check("t3_idle_after", {31'd0, busy}, 32'd0);
    check("t3_req_count", req_cnt - base_r, 32'd8);

    // 4: back-pressure on Occ request and on result
    c_mem[2] = 8'd10;
    base_r = req_cnt;
    bus.occ_req_ready = 1'b0;
    send_cmd(8'd3, 8'd9, 2'd2, 1'b0);
    lat = 0;
    while (!bus.occ_req_valid && lat < 10) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_req_valid_c%0d", i), {31'd0, bus.occ_req_valid}, 32'd1);
      check($sformatf("t4_req_sym_c%0d", i),   {30'd0, bus.occ_sym},       32'd2);
      check($sformatf("t4_req_pos_c%0d", i),   {24'd0, bus.occ_pos},       32'd2);
      tick();
    end
    bus.occ_req_ready = 1'b1;
    bus.res_ready     = 1'b0;
    wait_res(lat);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_res_valid_c%0d", i), {31'd0, bus.res_valid}, 32'd1);
      check_res($sformatf("t4_c%0d", i), 2'd2, 8'd12, 8'd14, 1'b0, 1'b1);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("t4_res_valid_after", {31'd0, bus.res_valid}, 32'd0);
    check("t4_idle_after", {31'd0, busy}, 32'd0);
    check("t4_req_count", req_cnt - base_r, 32'd2);
    check("t4_pos1", {24'd0, pos_hist[base_r + 1]}, 32'd9);

    // 5: inverted interval
    base_c = c_ce_cnt;
    base_r = req_cnt;
    send_cmd(8'd7, 8'd4, 2'd0, 1'b0);
    wait_res(lat);
    check("t5_latency", lat, 32'd1);
    check_res("t5", 2'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    tick();
    check("t5_c_ce_count", c_ce_cnt - base_c, 32'd0);
    check("t5_req_count",  req_cnt - base_r,  32'd0);

    // 6: reset while waiting for an Occ response, then a stale response
    rsp_en = 1'b0;
    send_cmd(8'd3, 8'd9, 2'd2, 1'b0);
    lat = 0;
    while (!bus.occ_req_valid && lat < 10) begin
      tick();
      lat++;
    end
    tick();
    check("t6_waiting_busy", {31'd0, busy}, 32'd1);
    check("t6_waiting_req",  {31'd0, bus.occ_req_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("t6_rst_busy",      {31'd0, busy},          32'd0);
    check("t6_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    stale_inj = 1'b1;
    tick();
    stale_inj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_stale_busy_c%0d", i),  {31'd0, busy},          32'd0);
      check($sformatf("t6_stale_res_c%0d", i),   {31'd0, bus.res_valid}, 32'd0);
      tick();
    end
    rsp_en = 1'b1;
    c_mem[1] = 8'd4;
    send_cmd(8'd0, 8'd5, 2'd1, 1'b0);
    wait_res(lat);
    check("t6_latency", lat, 32'd4);
    check_res("t6", 2'd1, 8'd5, 8'd6, 1'b0, 1'b1);
    tick();

    // 7: modular wrap, C=250, occK=10, occL=12
    c_mem[3] = 8'd250;
    occ_mem[3][4] = 8'd10;
    occ_mem[3][8] = 8'd12;
    send_cmd(8'd5, 8'd8, 2'd3, 1'b0);
    wait_res(lat);
    check("t7_latency", lat, 32'd6);
    check_res("t7", 2'd3, 8'd5, 8'd6, 1'b0, 1'b1);
    tick();
    check("t7_idle_after", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
